ysyx_25030081_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute-stage ALU; the ALU result is consumed as the effective address. It accepts one memory operation at a time, issues a single-beat request on a simple valid/ready memory bus, waits for the response, and aligns and extends the load data. Results go to writeback over a valid/ready handshake. Non-memory operations pass the ALU result through unchanged so writeback sees a uniform path.

---
 rtl/ysyx_25030081_lsu.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_25030081_lsu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit fed by the execute-stage ALU. Handles one operation at a time:
// legal loads/stores issue a single-beat request on a valid/ready bus, wait for the
// response and return aligned, extended data; illegal or misaligned ops and
// non-memory ops complete immediately without touching the bus.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_*                  upstream op (valid/ready), ALU result as address, store data
//   mem_req_*, mem_addr,  bus request channel (word-aligned address, byte strobes)
//   mem_wen, mem_wdata,
//   mem_wmask
//   mem_rsp_valid,        bus response / write ack
//   mem_rdata
//   out_*                 result to writeback (valid/ready), error flag
module ysyx_25030081_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [2:0]            in_funct3,
  input  logic                  in_load,
  input  logic                  in_store,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;   // already lane-shifted
  logic [3:0]            wmask_q, wmask_d;
  logic                  wen_q, wen_d;
  logic                  load_q, load_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  err_q, err_d;

  // Decode of the incoming op.
  logic [1:0] off;
  logic       illegal;
  logic [3:0] st_mask;
  logic       in_fire;

  assign off     = in_addr[1:0];
  assign in_fire = in_valid && (state_q == StIdle);

  always_comb begin
    illegal = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = in_addr[0];
      3'b010:         illegal = (off != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  // Size comes from funct3[1:0]; the sign bit is irrelevant for stores.
  always_comb begin
    st_mask = 4'b1111;
    case (in_funct3[1:0])
      2'b00:   st_mask = 4'b0001 << off;
      2'b01:   st_mask = 4'b0011 << off;
      default: st_mask = 4'b1111;
    endcase
  end

  // Load alignment: bring the addressed byte/half down to bit 0, then extend.
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] ld_data;

  assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = rd_shift;
    case (funct3_q)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'b0, rd_shift[7:0]};
      3'b101:  ld_data = {16'b0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    wen_d    = wen_q;
    load_d   = load_q;
    funct3_d = funct3_q;
    res_d    = res_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          addr_d   = in_addr;
          funct3_d = in_funct3;
          load_d   = in_load;
          wen_d    = in_store;
          wdata_d  = in_wdata << {off, 3'b000};
          wmask_d  = in_store ? st_mask : 4'b0000;
          res_d    = '0;
          err_d    = 1'b0;
          if (!in_load && !in_store) begin
            res_d   = DATA_WIDTH'(in_addr);
            state_d = StDone;
          end else if (illegal) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          res_d   = load_q ? ld_data : '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      wen_q    <= 1'b0;
      load_q   <= 1'b0;
      funct3_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      wen_q    <= wen_d;
      load_q   <= load_d;
      funct3_q <= funct3_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign mem_req_valid = (state_q == StReq);
  assign mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // Write controls are only presented while a request is outstanding.
  assign mem_wen       = wen_q && (state_q == StReq);
  assign mem_wmask     = (state_q == StReq) ? wmask_q : 4'b0000;
  assign mem_wdata     = wdata_q;
  assign out_valid     = (state_q == StDone);
  assign out_data      = res_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic        in_load, in_store;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_err;

  always #5 clk = ~clk;

  ysyx_25030081_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_funct3     (in_funct3),
    .in_load       (in_load),
    .in_store      (in_store),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err       (out_err)
  );

  int tests  = 0;
  int failed = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endfunction

  // Results of the last run_op.
  logic [31:0] r_data, r_maddr, r_mwdata;
  logic        r_err, r_wen;
  logic [3:0]  r_mask;
  int          r_nreq, r_lat, r_unstable;
  logic        r_timeout, r_inready_after;

  // Drive one op and act as bus + writeback with the given stall counts.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                        input int out_dly);
    int req_wait, rsp_wait, out_wait, k;
    bit seen, oseen, pending, done;
    r_data = '0; r_err = 1'b0; r_maddr = '0; r_wen = 1'b0; r_mask = '0; r_mwdata = '0;
    r_nreq = 0; r_lat = -1; r_unstable = 0; r_timeout = 1'b0;
    req_wait = 0; rsp_wait = 0; out_wait = 0;
    seen = 0; oseen = 0; pending = 0; done = 0;
    @(negedge clk);
    chk("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; mem_rdata = rdata;
    k = 0;
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
      in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0;
      if (in_ready) r_unstable++;
      if (mem_req_valid) begin
        if (!seen) begin
          seen = 1; r_maddr = mem_addr; r_wen = mem_wen; r_mask = mem_wmask;
          r_mwdata = mem_wdata;
        end else if (mem_addr !== r_maddr || mem_wen !== r_wen || mem_wmask !== r_mask ||
                     mem_wdata !== r_mwdata) begin
          r_unstable++;
        end
        if (req_wait >= rdy_dly) begin
          mem_req_ready = 1'b1; r_nreq++; pending = 1; rsp_wait = 0;
        end else begin
          req_wait++;
        end
      end else if (pending) begin
        if (rsp_wait >= rsp_dly) begin
          mem_rsp_valid = 1'b1; pending = 0;
        end else begin
          rsp_wait++;
        end
      end
      if (out_valid) begin
        if (!oseen) begin
          oseen = 1; r_lat = k; r_data = out_data; r_err = out_err;
        end else if (out_data !== r_data || out_err !== r_err) begin
          r_unstable++;
        end
        if (out_wait >= out_dly) begin
          out_ready = 1'b1; done = 1;
        end else begin
          out_wait++;
        end
      end
    end
    if (!done) r_timeout = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    r_inready_after = in_ready;
  endtask

  task automatic check_res(string nm, logic [31:0] e_data, logic e_err, int e_nreq, int e_lat,
                           logic [31:0] e_maddr, logic e_wen, logic [3:0] e_mask,
                           logic [31:0] e_mwdata);
    chk({nm, "_timeout"}, {31'b0, r_timeout}, 32'd0);
    chk({nm, "_data"}, r_data, e_data);
    chk({nm, "_err"}, {31'b0, r_err}, {31'b0, e_err});
    chk({nm, "_nreq"}, 32'(r_nreq), 32'(e_nreq));
    chk({nm, "_latency"}, 32'(r_lat), 32'(e_lat));
    chk({nm, "_stable"}, 32'(r_unstable), 32'd0);
    chk({nm, "_in_ready_after"}, {31'b0, r_inready_after}, 32'd1);
    if (e_nreq != 0) begin
      chk({nm, "_mem_addr"}, r_maddr, e_maddr);
      chk({nm, "_mem_wen"}, {31'b0, r_wen}, {31'b0, e_wen});
      chk({nm, "_mem_wmask"}, {28'b0, r_mask}, {28'b0, e_mask});
      if (e_wen) chk({nm, "_mem_wdata"}, r_mwdata, e_mwdata);
    end
  endtask

  // Reference model: computed straight from the addressing/extension rules.
  logic [31:0] m_data, m_maddr, m_mwdata;
  logic        m_err, m_wen;
  logic [3:0]  m_mask;
  int          m_nreq;

  function automatic void model(logic ld, logic st, int f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata);
    int off, sz;
    logic [31:0] w;
    bit bad;
    off = int'(addr % 4);
    sz = f3 % 4;
    m_data = 0; m_err = 0; m_nreq = 0; m_maddr = addr - 32'(off);
    m_wen = 0; m_mask = 0; m_mwdata = 0;
    if (!ld && !st) begin
      m_data = addr;
      return;
    end
    bad = (f3 == 3 || f3 == 6 || f3 == 7) || (sz == 1 && addr % 2 == 1) ||
          (sz == 2 && off != 0);
    if (bad) begin
      m_err = 1;
      return;
    end
    m_nreq = 1;
    if (st) begin
      m_wen = 1;
      m_mask = 4'((sz == 0 ? 1 : sz == 1 ? 3 : 15) << off);
      m_mwdata = wdata << (8 * off);
    end else begin
      w = rdata >> (8 * off);
      case (f3)
        0: m_data = (w % 256 >= 128) ? (w % 256) + 32'hFFFFFF00 : w % 256;
        1: m_data = (w % 65536 >= 32768) ? (w % 65536) + 32'hFFFF0000 : w % 65536;
        4: m_data = w % 256;
        5: m_data = w % 65536;
        default: m_data = w;
      endcase
    end
  endfunction

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] e_data;
    logic        e_err;
    int          e_nreq;
    logic [31:0] e_maddr;
    logic        e_wen;
    logic [3:0]  e_mask;
    logic [31:0] e_mwdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int ldsel, f3, rdy, rsp, od, lat;
    logic [31:0] a, wd, rd;
    logic ld, st;

    vecs.push_back('{"lw",   1, 0, 3'b010, 32'h80000010, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1,
                     32'h80000010, 0, 4'b0000, 0});
    vecs.push_back('{"lb",   1, 0, 3'b000, 32'h80000003, 0, 32'h80FF1234, 32'hFFFFFF80, 0, 1,
                     32'h80000000, 0, 4'b0000, 0});
    vecs.push_back('{"lbu",  1, 0, 3'b100, 32'h80000003, 0, 32'h80FF1234, 32'h00000080, 0, 1,
                     32'h80000000, 0, 4'b0000, 0});
    vecs.push_back('{"lh",   1, 0, 3'b001, 32'h80000002, 0, 32'h80FF1234, 32'hFFFF80FF, 0, 1,
                     32'h80000000, 0, 4'b0000, 0});
    vecs.push_back('{"lhu",  1, 0, 3'b101, 32'h80000002, 0, 32'h80FF1234, 32'h000080FF, 0, 1,
                     32'h80000000, 0, 4'b0000, 0});
    vecs.push_back('{"sh",   0, 1, 3'b001, 32'h80000006, 32'h0000ABCD, 0, 0, 0, 1,
                     32'h80000004, 1, 4'b1100, 32'hABCD0000});
    vecs.push_back('{"sb",   0, 1, 3'b000, 32'h80000001, 32'h123456AB, 0, 0, 0, 1,
                     32'h80000000, 1, 4'b0010, 32'h3456AB00});
    vecs.push_back('{"sw",   0, 1, 3'b010, 32'h8000000C, 32'hCAFEF00D, 0, 0, 0, 1,
                     32'h8000000C, 1, 4'b1111, 32'hCAFEF00D});
    vecs.push_back('{"lw_mis", 1, 0, 3'b010, 32'h80000002, 0, 32'h11111111, 0, 1, 0,
                     0, 0, 4'b0000, 0});
    vecs.push_back('{"f3_011", 1, 0, 3'b011, 32'h80000000, 0, 32'h11111111, 0, 1, 0,
                     0, 0, 4'b0000, 0});
    vecs.push_back('{"lhu_mis", 1, 0, 3'b101, 32'h80000001, 0, 32'h11111111, 0, 1, 0,
                     0, 0, 4'b0000, 0});
    vecs.push_back('{"sw_mis", 0, 1, 3'b010, 32'h80000003, 32'h1, 0, 0, 1, 0,
                     0, 0, 4'b0000, 0});
    vecs.push_back('{"nonmem", 0, 0, 3'b010, 32'h00001234, 32'h5, 32'h7, 32'h00001234, 0, 0,
                     0, 0, 4'b0000, 0});

    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
    in_load = 1'b0; in_store = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);

    // Directed vectors with an immediate bus and writeback.
    foreach (vecs[i]) begin
      run_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
             0, 0, 0);
      check_res(vecs[i].name, vecs[i].e_data, vecs[i].e_err, vecs[i].e_nreq,
                vecs[i].e_nreq != 0 ? 3 : 1, vecs[i].e_maddr, vecs[i].e_wen, vecs[i].e_mask,
                vecs[i].e_mwdata);
    end

    // Backpressure on every channel.
    run_op(1, 0, 3'b010, 32'h80000040, 0, 32'h0BADF00D, 3, 2, 2);
    check_res("bp_lw", 32'h0BADF00D, 0, 1, 8, 32'h80000040, 0, 4'b0000, 0);
    run_op(0, 1, 3'b000, 32'h80000042, 32'h000000EE, 0, 3, 2, 2);
    check_res("bp_sb", 32'h0, 0, 1, 8, 32'h80000040, 1, 4'b0100, 32'h00EE0000);

    // Reset while waiting for a response, then a stray response.
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h80000020; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    in_valid = 1'b0; in_load = 1'b0;
    chk("rw_req_valid", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rw_in_wait", {30'b0, mem_req_valid, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_after_rst", {29'b0, in_ready, out_valid, mem_req_valid}, 32'b100);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rw_stray_rsp", {29'b0, in_ready, out_valid, mem_req_valid}, 32'b100);
    run_op(0, 0, 3'b000, 32'h00001234, 0, 0, 0, 0, 0);
    check_res("rw_nonmem", 32'h00001234, 0, 0, 1, 0, 0, 4'b0000, 0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      ldsel = int'($urandom_range(0, 2));
      ld = (ldsel == 0); st = (ldsel == 1);
      if (st) begin
        case ($urandom_range(0, 5))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 2; 3: f3 = 3; 4: f3 = 6; default: f3 = 7;
        endcase
      end else begin
        f3 = int'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
      wd = $urandom; rd = $urandom;
      rdy = int'($urandom_range(0, 3));
      rsp = int'($urandom_range(0, 3));
      od = int'($urandom_range(0, 3));
      model(ld, st, f3, a, wd, rd);
      lat = (m_nreq != 0) ? 3 + rdy + rsp : 1;
      run_op(ld, st, 3'(f3), a, wd, rd, rdy, rsp, od);
      check_res($sformatf("rand%0d", n), m_data, m_err, m_nreq, lat, m_maddr, m_wen, m_mask,
                m_mwdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
